// File: rtl/gba_cart_reader.sv
// GBA-side cartridge ROM bus initiator: one address phase per segment, then
// sequential RD strobes, each returned halfword offered on a valid/ready slot.
module gba_cart_reader #(
  parameter int ADDR_SETUP = 6,
  parameter int RD_LOW     = 8,
  parameter int RD_HIGH    = 4,
  parameter int CS_HIGH    = 4,
  parameter int LEN_W      = 9
) (
  input  logic             clk100,
  input  logic             reset,
  input  logic             start,
  input  logic [23:0]      start_addr,
  input  logic [LEN_W-1:0] len,
  output logic             busy,
  output logic             done,
  output logic [15:0]      data_out,
  output logic             data_valid,
  input  logic             data_ready,
  output logic             cart_cs_n,
  output logic             cart_rd_n,
  output logic [7:0]       cart_ah,
  output logic [15:0]      cart_ad_out,
  output logic             cart_ad_oe,
  input  logic [15:0]      cart_ad_in
);

  // state   | meaning
  // IDLE    | bus released, waiting for start
  // PRE     | drive address on AD/AH with CS still high
  // ADDR    | CS low, address held for setup
  // TURN    | AD released before RD may fall
  // RD_LO   | RD low, AD sampled in final cycle
  // RD_HI   | RD high between strobes
  // HOLD    | CS low, RD high until output slot drains
  // GAP     | CS high before next segment or end of burst
  typedef enum logic [2:0] {
    S_IDLE, S_PRE, S_ADDR, S_TURN, S_RD_LO, S_RD_HI, S_HOLD, S_GAP
  } state_t;

  localparam int TMR_W = 8;
  localparam logic [TMR_W-1:0] T_ADDR  = TMR_W'(ADDR_SETUP - 1);
  localparam logic [TMR_W-1:0] T_RD_LO = TMR_W'(RD_LOW - 1);
  localparam logic [TMR_W-1:0] T_RD_HI = TMR_W'(RD_HIGH - 1);
  localparam logic [TMR_W-1:0] T_GAP   = TMR_W'(CS_HIGH - 1);

  state_t            state, state_nx;
  logic [TMR_W-1:0]  tmr, tmr_nx;
  logic [23:0]       addr;
  logic [LEN_W-1:0]  rem;
  logic [23:0]       seg_addr;
  logic              tc, accept, zero_len, capture, load_seg, finish, stall;

  assign tc    = (tmr == '0);
  assign stall = data_valid && !data_ready;

  always_comb begin
    state_nx   = state;
    tmr_nx     = tc ? tmr : tmr - 1'b1;
    accept     = 1'b0;
    zero_len   = 1'b0;
    capture    = 1'b0;
    load_seg   = 1'b0;
    finish     = 1'b0;
    seg_addr   = addr;
    cart_cs_n  = 1'b1;
    cart_rd_n  = 1'b1;
    cart_ad_oe = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) begin
          if (len != '0) begin
            accept   = 1'b1;
            load_seg = 1'b1;
            seg_addr = start_addr;
            state_nx = S_PRE;
          end else begin
            zero_len = 1'b1;
          end
        end
      end
      S_PRE: begin
        cart_ad_oe = 1'b1;
        state_nx   = S_ADDR;
        tmr_nx     = T_ADDR;
      end
      S_ADDR: begin
        cart_cs_n  = 1'b0;
        cart_ad_oe = 1'b1;
        if (tc) state_nx = S_TURN;
      end
      S_TURN: begin
        cart_cs_n = 1'b0;
        // a halfword left over from the previous segment must drain first
        if (stall) begin
          state_nx = S_HOLD;
        end else begin
          state_nx = S_RD_LO;
          tmr_nx   = T_RD_LO;
        end
      end
      S_RD_LO: begin
        cart_cs_n = 1'b0;
        cart_rd_n = 1'b0;
        if (tc) begin
          capture  = 1'b1;
          state_nx = S_RD_HI;
          tmr_nx   = T_RD_HI;
        end
      end
      S_RD_HI: begin
        cart_cs_n = 1'b0;
        if (tc) begin
          if (rem == '0 || addr[15:0] == 16'h0000) begin
            state_nx = S_GAP;
            tmr_nx   = T_GAP;
          end else if (stall) begin
            state_nx = S_HOLD;
          end else begin
            state_nx = S_RD_LO;
            tmr_nx   = T_RD_LO;
          end
        end
      end
      S_HOLD: begin
        cart_cs_n = 1'b0;
        if (!stall) begin
          state_nx = S_RD_LO;
          tmr_nx   = T_RD_LO;
        end
      end
      S_GAP: begin
        if (tc) begin
          if (rem == '0) begin
            finish   = 1'b1;
            state_nx = S_IDLE;
          end else begin
            load_seg = 1'b1;
            state_nx = S_PRE;
          end
        end
      end
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk100 or posedge reset) begin
    if (reset) begin
      state       <= S_IDLE;
      tmr         <= '0;
      addr        <= '0;
      rem         <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      data_out    <= '0;
      data_valid  <= 1'b0;
      cart_ah     <= '0;
      cart_ad_out <= '0;
    end else begin
      state <= state_nx;
      tmr   <= tmr_nx;
      done  <= zero_len || finish;
      if (accept) begin
        addr <= start_addr;
        rem  <= len;
        busy <= 1'b1;
      end
      if (finish) busy <= 1'b0;
      if (load_seg) begin
        cart_ah     <= seg_addr[23:16];
        cart_ad_out <= seg_addr[15:0];
      end
      if (capture) begin
        data_out   <= cart_ad_in;
        data_valid <= 1'b1;
        addr       <= addr + 24'd1;
        rem        <= rem - 1'b1;
      end else if (data_valid && data_ready) begin
        data_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_gba_cart_reader.sv
// Bench for gba_cart_reader: cartridge responder model, bus monitor and
// per-scenario tasks comparing received halfwords against a linear ROM model.
module tb_gba_cart_reader;
  localparam int LEN_W = 9;

  logic             clk100 = 1'b0;
  logic             reset = 1'b1;
  logic             start = 1'b0;
  logic [23:0]      start_addr = '0;
  logic [LEN_W-1:0] len = '0;
  logic             busy, done, data_valid;
  logic             data_ready = 1'b1;
  logic [15:0]      data_out;
  logic             cart_cs_n, cart_rd_n, cart_ad_oe;
  logic [7:0]       cart_ah;
  logic [15:0]      cart_ad_out, cart_ad_in;

  int checks = 0;
  int failures = 0;

  gba_cart_reader dut (
    .clk100(clk100), .reset(reset), .start(start), .start_addr(start_addr),
    .len(len), .busy(busy), .done(done), .data_out(data_out),
    .data_valid(data_valid), .data_ready(data_ready), .cart_cs_n(cart_cs_n),
    .cart_rd_n(cart_rd_n), .cart_ah(cart_ah), .cart_ad_out(cart_ad_out),
    .cart_ad_oe(cart_ad_oe), .cart_ad_in(cart_ad_in)
  );

  always #5 clk100 = ~clk100;

  // ROM contents as a function of the full 24-bit halfword address
  function automatic logic [15:0] rom_val(input logic [23:0] a);
    if (a == 24'h000010) return 16'hBEEF;
    return a[15:0] ^ 16'h5A5A ^ {a[23:16], a[23:16]};
  endfunction

  // responder + monitor, sampled on the falling clock edge
  int rd_low_cycles = 0, cs_low_cycles = 0, rd_falls = 0, cs_falls = 0;
  int done_cycles = 0, oe_viol = 0, seg_oe_bad = 0, valid_cycles = 0;
  int cs_high_run = 0, last_cs_high_run = 0, rx_wr = 0;
  logic [15:0] rx_mem [0:1023];
  logic [23:0] resp_addr = '0;
  logic [23:0] last_seg_addr = '0;
  bit prev_cs = 1'b1, prev_rd = 1'b1, prev_oe = 1'b0;

  assign cart_ad_in = cart_rd_n ? 16'hFFFF : rom_val(resp_addr);

  always @(negedge clk100) begin
    if (!cart_rd_n) rd_low_cycles++;
    if (!cart_cs_n) cs_low_cycles++;
    if (prev_rd && !cart_rd_n) rd_falls++;
    if (prev_cs && !cart_cs_n) begin
      cs_falls++;
      last_cs_high_run = cs_high_run;
      resp_addr = {cart_ah, cart_ad_out};
      last_seg_addr = {cart_ah, cart_ad_out};
      if (!cart_ad_oe) seg_oe_bad++;
    end
    if (cart_cs_n) cs_high_run++;
    else cs_high_run = 0;
    if (!prev_rd && cart_rd_n && !cart_cs_n) resp_addr[15:0] = resp_addr[15:0] + 16'd1;
    if (done) done_cycles++;
    if (data_valid) valid_cycles++;
    if (data_valid && data_ready) begin
      rx_mem[rx_wr % 1024] = data_out;
      rx_wr++;
    end
    if (!cart_rd_n && (cart_ad_oe || prev_oe)) oe_viol++;
    prev_cs = cart_cs_n;
    prev_rd = cart_rd_n;
    prev_oe = cart_ad_oe;
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk100);
      #1;
    end
  endtask

  task automatic do_burst(input logic [23:0] a, input logic [LEN_W-1:0] n,
                          input int ready_mode, output bit timed_out);
    data_ready = 1'b1;
    start = 1'b1;
    start_addr = a;
    len = n;
    step(1);
    start = 1'b0;
    timed_out = 1'b1;
    for (int k = 0; k < 5000; k++) begin
      data_ready = (ready_mode != 0) ? 1'($urandom_range(0, 1)) : 1'b1;
      step(1);
      if (done) begin
        timed_out = 1'b0;
        break;
      end
    end
    data_ready = 1'b1;
    step(2);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    step(3);
    checks++;
    if ({cart_cs_n, cart_rd_n, cart_ad_oe, busy, done, data_valid} !== 6'b110000) begin
      failures++;
      $display("FAIL reset_ctrl got=%b exp=110000", {cart_cs_n, cart_rd_n, cart_ad_oe, busy, done, data_valid});
    end
    checks++;
    if ({cart_ah, cart_ad_out} !== 24'h0) begin
      failures++; $display("FAIL reset_addr got=%h exp=000000", {cart_ah, cart_ad_out});
    end
    checks++;
    if (data_out !== 16'h0) begin failures++; $display("FAIL reset_data got=%h exp=0000", data_out); end
    reset = 1'b0;
    step(2);
  endtask

  task automatic test_single();
    int r0 = rx_wr, rf = rd_falls, rl = rd_low_cycles, cl = cs_low_cycles;
    int vc = valid_cycles, dc = done_cycles, cf = cs_falls;
    bit to;
    do_burst(24'h000010, 9'd1, 0, to);
    checks++; if (to) begin failures++; $display("FAIL single_timeout got=timeout exp=done"); end
    checks++; if (rx_wr - r0 != 1) begin failures++; $display("FAIL single_count got=%0d exp=1", rx_wr - r0); end
    checks++; if (rx_mem[r0 % 1024] !== 16'hBEEF) begin failures++; $display("FAIL single_data got=%h exp=beef", rx_mem[r0 % 1024]); end
    checks++; if (rd_falls - rf != 1) begin failures++; $display("FAIL single_rd_pulses got=%0d exp=1", rd_falls - rf); end
    checks++; if (rd_low_cycles - rl != 8) begin failures++; $display("FAIL single_rd_low got=%0d exp=8", rd_low_cycles - rl); end
    checks++; if (cs_low_cycles - cl != 19) begin failures++; $display("FAIL single_cs_low got=%0d exp=19", cs_low_cycles - cl); end
    checks++; if (valid_cycles - vc != 1) begin failures++; $display("FAIL single_valid_len got=%0d exp=1", valid_cycles - vc); end
    checks++; if (done_cycles - dc != 1) begin failures++; $display("FAIL single_done got=%0d exp=1", done_cycles - dc); end
    checks++; if (cs_falls - cf != 1) begin failures++; $display("FAIL single_cs_falls got=%0d exp=1", cs_falls - cf); end
    reset = 1'b1;
    step(1);
    checks++; if ({cart_cs_n, busy, data_valid} !== 3'b100) begin failures++; $display("FAIL single_reset got=%b exp=100", {cart_cs_n, busy, data_valid}); end
    reset = 1'b0;
    step(2);
  endtask

  task automatic test_burst4();
    int r0 = rx_wr, rf = rd_falls, cf = cs_falls;
    bit to;
    do_burst(24'h000100, 9'd4, 0, to);
    checks++; if (to) begin failures++; $display("FAIL burst4_timeout got=timeout exp=done"); end
    checks++; if (rx_wr - r0 != 4) begin failures++; $display("FAIL burst4_count got=%0d exp=4", rx_wr - r0); end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (rx_mem[(r0 + i) % 1024] !== rom_val(24'h000100 + 24'(i))) begin
        failures++; $display("FAIL burst4_data[%0d] got=%h exp=%h", i, rx_mem[(r0 + i) % 1024], rom_val(24'h000100 + 24'(i)));
      end
    end
    checks++; if (rd_falls - rf != 4) begin failures++; $display("FAIL burst4_rd_pulses got=%0d exp=4", rd_falls - rf); end
    checks++; if (cs_falls - cf != 1) begin failures++; $display("FAIL burst4_cs_falls got=%0d exp=1", cs_falls - cf); end
  endtask

  task automatic test_wrap();
    int r0 = rx_wr, cf = cs_falls;
    bit to;
    do_burst(24'h01FFFE, 9'd4, 0, to);
    checks++; if (to) begin failures++; $display("FAIL wrap_timeout got=timeout exp=done"); end
    checks++; if (cs_falls - cf != 2) begin failures++; $display("FAIL wrap_cs_falls got=%0d exp=2", cs_falls - cf); end
    checks++; if (last_cs_high_run < 4) begin failures++; $display("FAIL wrap_gap got=%0d exp>=4", last_cs_high_run); end
    checks++; if (last_seg_addr !== 24'h020000) begin failures++; $display("FAIL wrap_seg_addr got=%h exp=020000", last_seg_addr); end
    checks++; if (rx_wr - r0 != 4) begin failures++; $display("FAIL wrap_count got=%0d exp=4", rx_wr - r0); end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (rx_mem[(r0 + i) % 1024] !== rom_val(24'h01FFFE + 24'(i))) begin
        failures++; $display("FAIL wrap_data[%0d] got=%h exp=%h", i, rx_mem[(r0 + i) % 1024], rom_val(24'h01FFFE + 24'(i)));
      end
    end
  endtask

  task automatic test_backpressure();
    int r0 = rx_wr, rf = rd_falls, stall_bad = 0;
    logic [23:0] a = 24'h003000 + 24'($urandom_range(0, 255));
    logic [15:0] held;
    bit got = 1'b0, fin = 1'b0;
    data_ready = 1'b1;
    start = 1'b1; start_addr = a; len = 9'd3;
    step(1);
    start = 1'b0;
    for (int k = 0; k < 200 && !got; k++) begin
      step(1);
      if (data_valid) got = 1'b1;
    end
    checks++; if (!got) begin failures++; $display("FAIL bp_first_valid got=timeout exp=valid"); end
    data_ready = 1'b0;
    held = data_out;
    repeat (20) begin
      step(1);
      if (cart_rd_n !== 1'b1 || cart_cs_n !== 1'b0 || data_out !== held || data_valid !== 1'b1) stall_bad++;
    end
    checks++; if (stall_bad != 0) begin failures++; $display("FAIL bp_stall got=%0d bad cycles exp=0", stall_bad); end
    checks++; if (rd_falls - rf != 1) begin failures++; $display("FAIL bp_rd_during_stall got=%0d exp=1", rd_falls - rf); end
    data_ready = 1'b1;
    for (int k = 0; k < 300 && !fin; k++) begin
      step(1);
      if (done) fin = 1'b1;
    end
    step(2);
    checks++; if (!fin) begin failures++; $display("FAIL bp_timeout got=timeout exp=done"); end
    checks++; if (rx_wr - r0 != 3) begin failures++; $display("FAIL bp_count got=%0d exp=3", rx_wr - r0); end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (rx_mem[(r0 + i) % 1024] !== rom_val(a + 24'(i))) begin
        failures++; $display("FAIL bp_data[%0d] got=%h exp=%h", i, rx_mem[(r0 + i) % 1024], rom_val(a + 24'(i)));
      end
    end
    checks++; if (rd_falls - rf != 3) begin failures++; $display("FAIL bp_rd_pulses got=%0d exp=3", rd_falls - rf); end
  endtask

  task automatic test_len0();
    int cf = cs_falls, dc = done_cycles;
    start = 1'b1; start_addr = 24'($urandom); len = '0;
    step(1);
    start = 1'b0;
    checks++; if ({done, busy} !== 2'b10) begin failures++; $display("FAIL len0_done got=%b exp=10", {done, busy}); end
    step(1);
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL len0_done_width got=%b exp=0", done); end
    step(10);
    checks++; if (cs_falls != cf) begin failures++; $display("FAIL len0_cs got=%0d exp=%0d", cs_falls, cf); end
    checks++; if (done_cycles - dc != 1) begin failures++; $display("FAIL len0_done_count got=%0d exp=1", done_cycles - dc); end
  endtask

  task automatic test_busy_start();
    int r0 = rx_wr, dc = done_cycles, cf = cs_falls;
    logic [23:0] a = 24'h004000 + 24'($urandom_range(0, 255));
    bit fin = 1'b0;
    data_ready = 1'b1;
    start = 1'b1; start_addr = a; len = 9'd3;
    step(1);
    start = 1'b0;
    step(12);
    start = 1'b1; start_addr = 24'h00ABCD; len = 9'd7;
    step(1);
    start = 1'b0;
    for (int k = 0; k < 300 && !fin; k++) begin
      step(1);
      if (done) fin = 1'b1;
    end
    step(40);
    checks++; if (!fin) begin failures++; $display("FAIL busy_timeout got=timeout exp=done"); end
    checks++; if (rx_wr - r0 != 3) begin failures++; $display("FAIL busy_count got=%0d exp=3", rx_wr - r0); end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (rx_mem[(r0 + i) % 1024] !== rom_val(a + 24'(i))) begin
        failures++; $display("FAIL busy_data[%0d] got=%h exp=%h", i, rx_mem[(r0 + i) % 1024], rom_val(a + 24'(i)));
      end
    end
    checks++; if (done_cycles - dc != 1) begin failures++; $display("FAIL busy_done got=%0d exp=1", done_cycles - dc); end
    checks++; if (cs_falls - cf != 1) begin failures++; $display("FAIL busy_cs_falls got=%0d exp=1", cs_falls - cf); end
  endtask

  task automatic test_reset_mid();
    int r0;
    logic [23:0] a = 24'h005000 + 24'($urandom_range(0, 255));
    bit found = 1'b0, to;
    data_ready = 1'b1;
    start = 1'b1; start_addr = a; len = 9'd5;
    step(1);
    start = 1'b0;
    for (int k = 0; k < 100 && !found; k++) begin
      step(1);
      if (!cart_rd_n) found = 1'b1;
    end
    checks++; if (!found) begin failures++; $display("FAIL rmid_rd_low got=timeout exp=rd_low"); end
    #2 reset = 1'b1;
    #1;
    checks++; if ({cart_cs_n, cart_rd_n, cart_ad_oe} !== 3'b110) begin failures++; $display("FAIL rmid_bus got=%b exp=110", {cart_cs_n, cart_rd_n, cart_ad_oe}); end
    checks++; if ({busy, data_valid} !== 2'b00) begin failures++; $display("FAIL rmid_status got=%b exp=00", {busy, data_valid}); end
    step(1);
    reset = 1'b0;
    step(1);
    r0 = rx_wr;
    a = 24'h006000 + 24'($urandom_range(0, 255));
    do_burst(a, 9'd4, 1, to);
    checks++; if (to) begin failures++; $display("FAIL rmid_after_timeout got=timeout exp=done"); end
    checks++; if (rx_wr - r0 != 4) begin failures++; $display("FAIL rmid_after_count got=%0d exp=4", rx_wr - r0); end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (rx_mem[(r0 + i) % 1024] !== rom_val(a + 24'(i))) begin
        failures++; $display("FAIL rmid_after_data[%0d] got=%h exp=%h", i, rx_mem[(r0 + i) % 1024], rom_val(a + 24'(i)));
      end
    end
  endtask

  task automatic test_random();
    for (int t = 0; t < 8; t++) begin
      int r0 = rx_wr;
      logic [23:0] a = 24'($urandom);
      logic [LEN_W-1:0] n = LEN_W'($urandom_range(1, 20));
      int mode = int'($urandom_range(0, 1));
      bit to;
      if ($urandom_range(0, 1) == 1) a[15:0] = 16'hFFF0 + 16'($urandom_range(0, 15));
      if (t == 0) a = 24'hFFFFF8 + 24'($urandom_range(0, 7));
      do_burst(a, n, mode, to);
      checks++; if (to) begin failures++; $display("FAIL rand%0d_timeout got=timeout exp=done", t); end
      checks++; if (rx_wr - r0 != int'(n)) begin failures++; $display("FAIL rand%0d_count got=%0d exp=%0d", t, rx_wr - r0, n); end
      for (int i = 0; i < int'(n); i++) begin
        checks++;
        if (rx_mem[(r0 + i) % 1024] !== rom_val(a + 24'(i))) begin
          failures++; $display("FAIL rand%0d_data[%0d] got=%h exp=%h", t, i, rx_mem[(r0 + i) % 1024], rom_val(a + 24'(i)));
        end
      end
    end
  endtask

  task automatic test_protocol();
    checks++; if (oe_viol != 0) begin failures++; $display("FAIL oe_vs_rd got=%0d exp=0", oe_viol); end
    checks++; if (seg_oe_bad != 0) begin failures++; $display("FAIL addr_at_cs_fall got=%0d exp=0", seg_oe_bad); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_burst4();
    test_wrap();
    test_backpressure();
    test_len0();
    test_busy_start();
    test_reset_mid();
    test_random();
    test_protocol();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/gba_cart_reader.md
Name: gba_cart_reader

Overview:
- GBA-side bus initiator for the cartridge ROM interface. It generates CS/RD read cycles on the multiplexed 24-bit halfword address / 16-bit data bus.
- Used to read a real cartridge, or to drive our cartridge-ROM responder from a bench or a second FPGA.
- A host issues a burst (start address plus halfword count). The block performs one non-sequential address phase followed by sequential RD strobes, and returns each halfword over a valid/ready stream.
- Pad tristating is done externally in SB_IO; this block only exposes out/oe/in.

Parameters:
- ADDR_SETUP, 6: cycles CS is held low with the address driven, before turnaround.
- RD_LOW, 8: cycles RD is held low per halfword. Data is sampled in the last of these cycles.
- RD_HIGH, 4: cycles RD is held high between strobes.
- CS_HIGH, 4: minimum cycles CS is held high between bursts or segments.
- LEN_W, 9: width of the burst length.

Ports:
- clk100  in  1  system clock. Single clock domain.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle burst request. Sampled only in IDLE.
- start_addr  in  24  halfword address {AH, AD}.
- len  in  LEN_W  halfword count.
- busy  out  1  high from accepted start until done.
- done  out  1  one-cycle pulse when the burst completes.
- data_out  out  16  captured halfword.
- data_valid  out  1  data_out holds an unconsumed halfword.
- data_ready  in  1  consumer accepts when valid && ready.
- cart_cs_n  out  1  GBACART_CS drive.
- cart_rd_n  out  1  GBACART_RD drive.
- cart_ah  out  8  GBACART_AH (address high).
- cart_ad_out  out  16  AD output value.
- cart_ad_oe  out  1  AD output enable.
- cart_ad_in  in  16  AD pad input (unregistered).

Behaviour:
- Reset (asynchronous) values:
  - cart_cs_n=1, cart_rd_n=1, cart_ad_oe=0, cart_ad_out=0, cart_ah=0.
  - busy=0, done=0, data_valid=0, data_out=0.
  - State becomes IDLE.
- Reset mid-burst releases the bus in the same cycle and discards the remainder of the burst.
- States:
  - IDLE
  - PRE: 1 cycle. cs_n=1, oe=1, ad_out=addr[15:0], ah=addr[23:16].
  - ADDR: ADDR_SETUP cycles. cs_n=0, oe=1.
  - TURN: 1 cycle. cs_n=0, oe=0, rd_n=1.
  - RD_LO: RD_LOW cycles. rd_n=0, oe=0.
  - RD_HI: RD_HIGH cycles. rd_n=1.
  - HOLD: waits for the output slot to drain.
  - GAP: CS_HIGH cycles. cs_n=1.
- IDLE transitions:
  - start && len!=0: latch addr and remaining count (rem=len), set busy, go to PRE.
  - start && len==0: pulse done on the next cycle. No bus activity; busy stays 0.
- ADDR -> TURN -> RD_LO.
- Last cycle of RD_LO: data_out <= cart_ad_in, data_valid <= 1, addr <= addr+1, rem <= rem-1.
- RD_LO -> RD_HI.
- End of RD_HI:
  - rem==0: go to GAP, then IDLE with a done pulse; busy falls in the same cycle as done.
  - addr[15:0]==0 (low-16 wrap occurred): go to GAP, then PRE with the new addr. The cartridge counter wraps within 16 bits, so AH must be re-issued.
  - data_valid && !data_ready: go to HOLD. rd_n=1 and cs_n=0 are held until the slot is consumed, then go to RD_LO. RD never falls while data_valid is unconsumed at that point.
  - Otherwise: go to RD_LO.
- Stream handshake:
  - data_valid clears on valid && ready unless a new capture happens in the same cycle; in that case it stays 1 and data_out takes the new value.
  - A capture while valid is still set cannot occur (guaranteed by HOLD).
- start while busy is ignored.
- addr is 24 bits and wraps from 0xFFFFFF to 0x000000. This takes the segment-break path.
- cart_ad_oe is never 1 while cart_rd_n=0. oe falls at least one cycle before RD falls.
- Timing contract: the cartridge responder resynchronises RD/CS through a 3-flop chain. The defaults guarantee at least 4 cycles of margin for data on AD before sampling, and for the address on AD before the CS-fall detection.

Test Plan:
- Single read, then reset:
  - Stimulus: reset, then start_addr=0x000010, len=1, ready=1, responder model returns rom[0x10]=0xBEEF.
  - Required: exactly one RD low pulse of 8 cycles; data_out=0xBEEF with valid for 1 cycle; done once; cs_n low for 6+1+8+4 cycles.
- Burst of 4:
  - Stimulus: addr 0x000100, len=4, responder rom[i]=i^0x5A5A.
  - Required: 4 RD pulses with one CS assertion; outputs 0x5B5A, 0x5B5B, 0x5B58, 0x5B59.
- Low-16 wrap:
  - Stimulus: addr 0x01FFFE, len=4.
  - Required: CS rises after 2 strobes; GAP of ≥4 cycles; new address phase with ah=0x02, ad=0x0000; 4 halfwords total in order.
- Backpressure:
  - Stimulus: len=3, data_ready=0 for 20 cycles after the first valid.
  - Required: RD stays high, CS stays low, data_out stable; reads resume after ready; no halfword lost or duplicated.
- Edge cases:
  - len=0: done pulses one cycle later, cs_n never falls.
  - start asserted while busy: ignored.
- Reset mid-burst:
  - Stimulus: assert reset during RD_LO.
  - Required: cs_n, rd_n and oe release in the same cycle; valid=0; busy=0; a fresh start then works normally.
